solver_dispatcher: RTL and testbench
====================================

SOLVER_DISPATCHER -- requirements
Module: solver_dispatcher

Interface
REQ-001 Parameter DEPTH, default 4, meaning operand FIFO depth in entries, a power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles before abort; used only with DISPATCH_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  an X operand is offered.
REQ-006 in_ready  out  1  FIFO can accept; equals not-full.
REQ-007 in_x  in  8  X operand.
REQ-008 coef_load  in  1  latch coef_a/b/c.
REQ-009 coef_a, coef_b, coef_c  in  16 each  expression coefficients.
REQ-010 sol_start  out  1  start pulse to expression_solver.
REQ-011 sol_x  out  8 and sol_a/sol_b/sol_c  out  16  operands presented to the solver.
REQ-012 sol_result  in  16; sol_zero, sol_overflow, sol_completed  in  1  solver outputs.
REQ-013 out_valid  out  1 and out_ready  in  1  result handshake.
REQ-014 out_result  out  16; out_x  out  8; out_zero, out_overflow  out  1  captured result, source X and flags.
REQ-015 fifo_count  out  clog2(DEPTH+1)  current FIFO occupancy.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 A push occurs when in_valid and in_ready are both high, and in_x is written at the tail.
REQ-018 When full, in_ready is 0; a push is refused even if a pop occurs in the same cycle.
REQ-019 A simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_count unchanged.
REQ-020 Read and write pointers wrap modulo DEPTH.
REQ-021 Coefficients are latched on coef_load only while busy is 0; otherwise coef_load is ignored.
REQ-022 FSM states are IDLE, ISSUE, WAIT and HOLD.
REQ-023 IDLE: if the FIFO is not empty, pop the head into sol_x, copy the latched coefficients to sol_a/b/c, and go to ISSUE next cycle.
REQ-024 ISSUE: sol_start is 1 for exactly one cycle, then the FSM goes to WAIT.
REQ-025 sol_x and sol_a/b/c stay stable from ISSUE until the FSM leaves WAIT.
REQ-026 WAIT: in the first cycle sol_completed is 1, capture sol_result, sol_zero, sol_overflow and sol_x into the out_* registers, and go to HOLD.
REQ-027 HOLD: out_valid is 1; on out_valid and out_ready, go to IDLE next cycle.
REQ-028 out_valid is registered and is 1 only in HOLD.
REQ-029 Output latency from push into an empty idle FIFO to the ISSUE cycle is 2 cycles.
REQ-030 sol_completed outside WAIT is ignored.
REQ-031 Pushes continue in every state.

Reset
REQ-032 While rst is 0: the FSM is in IDLE, the FIFO is empty, fifo_count is 0 and in_ready is 1.
REQ-033 While rst is 0: sol_start, out_valid, busy, out_zero and out_overflow are 0; out_result, out_x, sol_x, sol_a/b/c and the coefficient registers are 0.
REQ-034 A reset mid-operation discards the in-flight operand, all FIFO contents and the held result.
REQ-035 The first dispatch after release requires a new push.

Configuration
REQ-036 Macro DISPATCH_TIMEOUT_EN, when defined, adds a WAIT cycle counter.
REQ-037 With DISPATCH_TIMEOUT_EN, reaching TIMEOUT cycles in WAIT without sol_completed moves the FSM to HOLD with out_result=0, out_zero=0, out_overflow=1 and out_x set to the issued X.
REQ-038 With DISPATCH_TIMEOUT_EN, an extra output timeout_err (1 bit) is registered high with that result and is cleared on its handshake.
REQ-039 Without DISPATCH_TIMEOUT_EN, WAIT lasts indefinitely and neither the timeout_err port nor the counter exists.

Structure
REQ-040 Package solver_pkg holds X_W=8, D_W=16 and the FSM state enum.
REQ-041 The FIFO is a sub-module dispatch_fifo with parameters DEPTH and width X_W, providing push, pop, full, empty and count.

Verification
REQ-042 Coefficients and single dispatch: load A=0x0060, B=0x0003, C=0x0001, push X=0x0F; sol_start pulses 1 cycle, 2 cycles after the push, with sol_x=0x0F and sol_a=0x0060; a solver stub returns 0x1234 after 5 cycles; out_valid=1, out_result=0x1234, out_x=0x0F.
REQ-043 FIFO full: with out_ready=0, push 5 operands at DEPTH=4; the 4 FIFO entries plus 1 in flight are accepted, then in_ready=0 and fifo_count=4; results drain in push order.
REQ-044 Backpressure: hold out_ready=0 for 10 cycles in HOLD; out_result stays stable; no second sol_start occurs until the handshake.
REQ-045 Reset mid-WAIT: drive rst=0 while in WAIT with 3 entries queued; all outputs take reset values immediately, fifo_count=0, and a late sol_completed has no effect.
REQ-046 Timeout (macro defined, TIMEOUT=8): the stub never completes; after 8 WAIT cycles, out_valid=1, out_overflow=1, out_result=0 and timeout_err=1.
REQ-047 Coefficient load while busy: coef_load with A=0xFFFF during WAIT is ignored; the next issue still uses A=0x0060.

Source files
------------

// File: rtl/solver_pkg.sv
// Shared widths and FSM state encoding for the solver dispatcher.
package solver_pkg;

    localparam int unsigned X_W = 8;
    localparam int unsigned D_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StHold
    } state_e;

endpackage

// File: rtl/dispatch_fifo.sv
// Operand FIFO for the solver dispatcher; DEPTH must be a power of two so the
// pointers wrap naturally.
module dispatch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // A push is refused when full, even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/solver_dispatcher.sv
// Queues X operands and issues them one at a time to an expression solver.
// Define DISPATCH_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
module solver_dispatcher
    import solver_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [X_W-1:0]             in_x,
    input  logic                       coef_load,
    input  logic [D_W-1:0]             coef_a,
    input  logic [D_W-1:0]             coef_b,
    input  logic [D_W-1:0]             coef_c,
    output logic                       sol_start,
    output logic [X_W-1:0]             sol_x,
    output logic [D_W-1:0]             sol_a,
    output logic [D_W-1:0]             sol_b,
    output logic [D_W-1:0]             sol_c,
    input  logic [D_W-1:0]             sol_result,
    input  logic                       sol_zero,
    input  logic                       sol_overflow,
    input  logic                       sol_completed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [D_W-1:0]             out_result,
    output logic [X_W-1:0]             out_x,
    output logic                       out_zero,
    output logic                       out_overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
`ifdef DISPATCH_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    state_e         state_q, state_d;
    logic [D_W-1:0] coef_a_q, coef_b_q, coef_c_q;
    logic [X_W-1:0] sol_x_q, out_x_q, fifo_rdata;
    logic [D_W-1:0] sol_a_q, sol_b_q, sol_c_q, out_result_q;
    logic           out_valid_q, out_zero_q, out_overflow_q;
    logic           fifo_full, fifo_empty, pop, capture, abort, handshake;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (X_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_x),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_err_q;
    logic             timed_out;

    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    assign pop       = (state_q == StIdle) && !fifo_empty;
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (sol_completed) begin
                    capture = 1'b1;
                    state_d = StHold;
`ifdef DISPATCH_TIMEOUT_EN
                end else if (timed_out) begin
                    abort   = 1'b1;
                    state_d = StHold;
`endif
                end
            end
            StHold:  if (handshake) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            coef_a_q       <= '0;
            coef_b_q       <= '0;
            coef_c_q       <= '0;
            sol_x_q        <= '0;
            sol_a_q        <= '0;
            sol_b_q        <= '0;
            sol_c_q        <= '0;
            out_result_q   <= '0;
            out_x_q        <= '0;
            out_zero_q     <= 1'b0;
            out_overflow_q <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == StHold);
            if (coef_load && (state_q == StIdle)) begin
                coef_a_q <= coef_a;
                coef_b_q <= coef_b;
                coef_c_q <= coef_c;
            end
            if (pop) begin
                sol_x_q <= fifo_rdata;
                sol_a_q <= coef_a_q;
                sol_b_q <= coef_b_q;
                sol_c_q <= coef_c_q;
            end
            if (capture) begin
                out_result_q   <= sol_result;
                out_zero_q     <= sol_zero;
                out_overflow_q <= sol_overflow;
                out_x_q        <= sol_x_q;
            end else if (abort) begin
                out_result_q   <= '0;
                out_zero_q     <= 1'b0;
                out_overflow_q <= 1'b1;
                out_x_q        <= sol_x_q;
            end
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + CNT_W'(1) : '0;
            if (abort) begin
                timeout_err_q <= 1'b1;
            end else if (handshake) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign in_ready     = !fifo_full;
    assign sol_start    = (state_q == StIssue);
    assign busy         = (state_q != StIdle);
    assign sol_x        = sol_x_q;
    assign sol_a        = sol_a_q;
    assign sol_b        = sol_b_q;
    assign sol_c        = sol_c_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_x        = out_x_q;
    assign out_zero     = out_zero_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_solver_dispatcher.sv
// Directed bench for solver_dispatcher with a fixed-latency solver stub.
module tb_solver_dispatcher;
    import solver_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic                       clk, rst;
    logic                       in_valid, in_ready;
    logic [X_W-1:0]             in_x;
    logic                       coef_load;
    logic [D_W-1:0]             coef_a, coef_b, coef_c;
    logic                       sol_start;
    logic [X_W-1:0]             sol_x;
    logic [D_W-1:0]             sol_a, sol_b, sol_c, sol_result;
    logic                       sol_zero, sol_overflow, sol_completed;
    logic                       out_valid, out_ready;
    logic [D_W-1:0]             out_result;
    logic [X_W-1:0]             out_x;
    logic                       out_zero, out_overflow;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       busy;
`ifdef DISPATCH_TIMEOUT_EN
    logic                       timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;

    solver_dispatcher #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .coef_load     (coef_load),
        .coef_a        (coef_a),
        .coef_b        (coef_b),
        .coef_c        (coef_c),
        .sol_start     (sol_start),
        .sol_x         (sol_x),
        .sol_a         (sol_a),
        .sol_b         (sol_b),
        .sol_c         (sol_c),
        .sol_result    (sol_result),
        .sol_zero      (sol_zero),
        .sol_overflow  (sol_overflow),
        .sol_completed (sol_completed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_x         (out_x),
        .out_zero      (out_zero),
        .out_overflow  (out_overflow),
        .fifo_count    (fifo_count),
        .busy          (busy)
`ifdef DISPATCH_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Solver stub: completes 5 cycles after the start pulse; it ignores reset
    // so a completion can arrive after the dispatcher has been cleared.
    logic [3:0] stub_cnt = 4'd0;
    logic       stub_use_x = 1'b0;
    logic       stub_never = 1'b0;

    always @(posedge clk) begin
        if (sol_start && !stub_never) stub_cnt <= 4'd5;
        else if (stub_cnt != 4'd0)    stub_cnt <= stub_cnt - 4'd1;
        if (sol_start) n_start <= n_start + 1;
    end

    assign sol_completed = (stub_cnt == 4'd1);
    assign sol_result    = stub_use_x ? {8'hA0, sol_x} : 16'h1234;
    assign sol_zero      = stub_use_x && (sol_x == 8'h33);
    assign sol_overflow  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] x);
        in_valid = 1'b1;
        in_x     = x;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!sol_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sol_start), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    initial begin
        int s;
        logic [7:0] ex;
        rst = 1'b0; in_valid = 1'b0; in_x = '0; coef_load = 1'b0;
        coef_a = '0; coef_b = '0; coef_c = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sol_start", 32'(sol_start), 0);
        check("rst_out_result", 32'(out_result), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single dispatch
        coef_load = 1'b1; coef_a = 16'h0060; coef_b = 16'h0003; coef_c = 16'h0001;
        @(negedge clk);
        coef_load = 1'b0;
        push(8'h0F);
        check("push_count", 32'(fifo_count), 1);
        check("no_early_start", 32'(sol_start), 0);
        @(negedge clk);
        check("issue_latency", 32'(sol_start), 1);
        check("issue_sol_x", 32'(sol_x), 32'h0F);
        check("issue_sol_a", 32'(sol_a), 32'h0060);
        check("issue_sol_b", 32'(sol_b), 32'h0003);
        check("issue_sol_c", 32'(sol_c), 32'h0001);
        @(negedge clk);
        check("start_one_cycle", 32'(sol_start), 0);
        check("wait_busy", 32'(busy), 1);
        coef_load = 1'b1; coef_a = 16'hFFFF;
        @(negedge clk);
        coef_load = 1'b0; coef_a = '0;
        check("sol_a_stable", 32'(sol_a), 32'h0060);
        wait_valid("result1_valid");
        check("result1_value", 32'(out_result), 32'h1234);
        check("result1_x", 32'(out_x), 32'h0F);
        check("result1_zero", 32'(out_zero), 0);

        // Backpressure with a queued operand
        push(8'h22);
        s = n_start;
        repeat (10) @(negedge clk);
        check("bp_result_stable", 32'(out_result), 32'h1234);
        check("bp_valid_held", 32'(out_valid), 1);
        check("bp_no_second_start", 32'(n_start), 32'(s));
        check("bp_queued", 32'(fifo_count), 1);
        handshake();
        check("valid_drop", 32'(out_valid), 0);
        wait_start("issue2_start");
        check("issue2_sol_x", 32'(sol_x), 32'h22);
        check("coef_ignored_busy", 32'(sol_a), 32'h0060);
        wait_valid("result2_valid");
        check("result2_x", 32'(out_x), 32'h22);
        handshake();

        // FIFO full: 4 queued + 1 in flight
        stub_use_x = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(8'h31 + 8'(i));
            if (i == 1) check("push_pop_same", 32'(fifo_count), 1);
        end
        check("full_in_ready", 32'(in_ready), 0);
        check("full_count", 32'(fifo_count), 4);
        push(8'h36);
        check("refuse_full", 32'(fifo_count), 4);
        for (int i = 0; i < 5; i++) begin
            ex = 8'h31 + 8'(i);
            wait_valid("drain_valid");
            check("drain_x", 32'(out_x), 32'(ex));
            check("drain_result", 32'(out_result), 32'({8'hA0, ex}));
            check("drain_zero", 32'(out_zero), (i == 2) ? 1 : 0);
            handshake();
        end
        stub_use_x = 1'b0;

        // Reset mid-WAIT with 3 queued
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
        check("pre_rst_count", 32'(fifo_count), 3);
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sol_x", 32'(sol_x), 0);
        check("mid_rst_sol_a", 32'(sol_a), 0);
        check("mid_rst_out_x", 32'(out_x), 0);
        check("mid_rst_out_result", 32'(out_result), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("late_done_valid", 32'(out_valid), 0);
        check("late_done_busy", 32'(busy), 0);
        check("late_done_result", 32'(out_result), 0);
        push(8'h46);
        wait_start("post_rst_start");
        check("post_rst_sol_x", 32'(sol_x), 32'h46);
        check("coef_reset", 32'(sol_a), 0);
        wait_valid("post_rst_valid");
        check("post_rst_out_x", 32'(out_x), 32'h46);
        handshake();

`ifdef DISPATCH_TIMEOUT_EN
        stub_never = 1'b1;
        push(8'h55);
        wait_start("tmo_start");
        repeat (8) @(negedge clk);
        check("tmo_not_early", 32'(out_valid), 0);
        @(negedge clk);
        check("tmo_valid", 32'(out_valid), 1);
        check("tmo_overflow", 32'(out_overflow), 1);
        check("tmo_result", 32'(out_result), 0);
        check("tmo_x", 32'(out_x), 32'h55);
        check("tmo_err", 32'(timeout_err), 1);
        handshake();
        check("tmo_err_clear", 32'(timeout_err), 0);
        stub_never = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
